rf_write_arbiter: RTL

Shares the single register-file write port between the in-order pipeline writeback (rd_write_w/rd_w/rd_data_w) and one long-latency unit (multi-cycle mul/div) using a valid/ready handshake. Long-unit results wait in a small FIFO until the port is idle. A 32-entry scoreboard of outstanding long-unit destinations drives a decode-stage hazard stall. Sits between the writeback stage, the long-latency unit and the register file in decode.

---
 rtl/rf_write_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-unit results queue in a
// small FIFO, and a scoreboard of outstanding long-unit destinations drives the decode stall.
// Optional same-cycle bypass of an idle port is enabled by defining RFARB_BYPASS_EN.
module rf_write_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_write_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] rd_data_w,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  output logic        hazard_d,
  output logic        bubble_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            bubble_q;
  logic [31:0]     pending_q, pending_d;

  logic pipe_win, accept, fifo_empty, push, pop, bypass;
  logic clr_en;
  logic [4:0] clr_rd;

  // rst_n gates the combinational paths so the outputs hold their reset values while reset is low.
  assign pipe_win   = rst_n && rd_write_w && (rd_w != 5'd0);
  assign lu_ready   = (count_q != Full);
  assign accept     = rst_n && lu_valid && lu_ready;
  assign fifo_empty = (count_q == '0);
  assign pop        = !pipe_win && !fifo_empty;
`ifdef RFARB_BYPASS_EN
  assign bypass     = accept && (lu_rd != 5'd0) && fifo_empty && !pipe_win;
`else
  assign bypass     = 1'b0;
`endif
  // x0 results are accepted but never stored.
  assign push       = accept && (lu_rd != 5'd0) && !bypass;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    clr_en   = 1'b0;
    clr_rd   = 5'd0;
    if (pipe_win) begin
      rf_we    = 1'b1;
      rf_waddr = rd_w;
      rf_wdata = rd_data_w;
    end else if (pop) begin
      rf_we    = 1'b1;
      rf_waddr = mem_q[rd_ptr_q].rd;
      rf_wdata = mem_q[rd_ptr_q].data;
      clr_en   = 1'b1;
      clr_rd   = mem_q[rd_ptr_q].rd;
    end else if (bypass) begin
      rf_we    = 1'b1;
      rf_waddr = lu_rd;
      rf_wdata = lu_data;
      clr_en   = 1'b1;
      clr_rd   = lu_rd;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Set is applied after clear so a same-register set wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  assign hazard_d   = pending_q[rs1_d] | pending_q[rs2_d] | pending_q[rd_d];
  assign bubble_req = bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bubble_q  <= 1'b0;
      pending_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bubble_q  <= (count_d == Full);
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{rd: lu_rd, data: lu_data};
    end
  end

endmodule
